// File: rtl/tlb_invtlb_sequencer.sv
// INVTLB sequencer: walks every TLB entry once per request, one entry per cycle.
// Each entry is read and matched against the latched op/asid/vpn2. On a hit, the
// entry's E bit is cleared through a registered write strobe one cycle later.
// busy stays high for the whole walk so the surrounding pipeline can stall lookups.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; outputs quiet
// SCAN  | reading entry cnt, registering its clear strobe
// DRAIN | last strobe visible; done pulse with hit count
// ERR   | unsupported op; done pulse with done_err, no writes
module tlb_invtlb_sequencer #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [4:0]      req_op_i,
  input  logic [7:0]      req_asid_i,
  input  logic [18:0]     req_vpn2_i,
  output logic            busy_o,
  output logic [IDXW-1:0] rd_idx_o,
  input  logic            rd_e_i,
  input  logic            rd_g_i,
  input  logic [7:0]      rd_asid_i,
  input  logic [18:0]     rd_vpn2_i,
  output logic            inv_we_o,
  output logic [IDXW-1:0] inv_idx_o,
  output logic            done_o,
  output logic            done_err_o,
  output logic [IDXW:0]   done_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_ERR
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);
  localparam logic [IDXW:0]   CNT_MAX  = (IDXW + 1)'(TLBNUM);

  state_t          state_q;
  logic [IDXW-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [7:0]      asid_q;
  logic [18:0]     vpn_q;
  logic            ready_q;
  logic            busy_q;
  logic            inv_we_q;
  logic [IDXW-1:0] inv_idx_q;
  logic            done_q;
  logic            done_err_q;
  logic [IDXW:0]   done_cnt_q;

  logic            asid_eq;
  logic            vpn_eq;
  logic            sel;
  logic            hit;

  // Match the entry currently on the read port against the latched request.
  always_comb begin
    asid_eq = (rd_asid_i == asid_q);
    vpn_eq  = (rd_vpn2_i == vpn_q);
    sel     = 1'b0;
    case (op_q)
      3'd0, 3'd1: sel = 1'b1;
      3'd2:       sel = rd_g_i;
      3'd3:       sel = !rd_g_i;
      3'd4:       sel = !rd_g_i && asid_eq;
      3'd5:       sel = !rd_g_i && asid_eq && vpn_eq;
      3'd6:       sel = (rd_g_i || asid_eq) && vpn_eq;
      default:    sel = 1'b0;
    endcase
    hit = rd_e_i && sel;
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      asid_q     <= '0;
      vpn_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      inv_we_q   <= 1'b0;
      inv_idx_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      inv_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && ready_q) begin
            done_cnt_q <= '0;
            ready_q    <= 1'b0;
            if (req_op_i < 5'd7) begin
              op_q    <= req_op_i[2:0];
              asid_q  <= req_asid_i;
              vpn_q   <= req_vpn2_i;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_SCAN;
            end else begin
              done_q     <= 1'b1;
              done_err_q <= 1'b1;
              state_q    <= S_ERR;
            end
          end
        end
        S_SCAN: begin
          inv_we_q  <= hit;
          inv_idx_q <= cnt_q;
          if (hit && (done_cnt_q != CNT_MAX)) begin
            done_cnt_q <= done_cnt_q + 1'b1;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rd_idx_o    = cnt_q;
  assign inv_we_o    = inv_we_q;
  assign inv_idx_o   = inv_idx_q;
  assign done_o      = done_q;
  assign done_err_o  = done_err_q;
  assign done_cnt_o  = done_cnt_q;

endmodule
